// File: rtl/regfile_ctx_engine.sv
// regfile_ctx_engine
//
// Moves architectural registers r1..rNUM_REGS between the register file and a
// word-aligned context area in memory. A save reads each register through the
// register-file read port and writes it to memory. A restore reads each word
// from memory and writes it back through the register-file write port. Word n
// lives at base + 4*(n-1); the address arithmetic wraps modulo 2^32.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   save_req            start a save (taken only in IDLE; wins over restore)
//   restore_req         start a restore (taken only in IDLE)
//   base_addr           context area byte address (bits [1:0] ignored)
//   busy, done          operation in progress / one-cycle completion pulse
//   rf_read_reg         register-file read address
//   rf_read_bus         read data, valid the cycle after rf_read_reg is driven
//   rf_reg_write,
//   rf_write_reg,
//   rf_write_bus        register-file write port
//   mem_req, mem_we,
//   mem_addr, mem_wdata memory request, held stable until mem_ack
//   mem_ack, mem_rdata  memory completion; mem_rdata valid with mem_ack
module regfile_ctx_engine #(
    parameter int NUM_REGS = 31
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        save_req,
    input  logic        restore_req,
    input  logic [31:0] base_addr,
    output logic        busy,
    output logic        done,
    output logic [4:0]  rf_read_reg,
    input  logic [31:0] rf_read_bus,
    output logic        rf_reg_write,
    output logic [4:0]  rf_write_reg,
    output logic [31:0] rf_write_bus,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SAVE_RD = 3'd1,
        SAVE_WR = 3'd2,
        RST_RD  = 3'd3,
        RST_WR  = 3'd4,
        DONE    = 3'd5
    } state_t;

    localparam logic [4:0] LAST_IDX = 5'(NUM_REGS);

    state_t      state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic [31:0] base_q, base_d;
    logic [31:0] wdata_q, wdata_d;
    logic        wr_first_q, wr_first_d;
    logic [31:0] rdata_q, rdata_d;

    logic [31:0] req_addr;
    logic [31:0] wdata_cur;
    logic        last_idx;

    // Byte offset of word idx is 4*(idx-1); the 32-bit add wraps naturally.
    assign req_addr = base_q + {25'd0, idx_q - 5'd1, 2'b00};
    assign last_idx = (idx_q == LAST_IDX);

    // The read data only arrives in the first SAVE_WR cycle, so it is passed
    // straight through then and served from wdata_q for the rest of the wait.
    assign wdata_cur = wr_first_q ? rf_read_bus : wdata_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= 5'd1;
            base_q     <= 32'd0;
            wdata_q    <= 32'd0;
            wr_first_q <= 1'b0;
            rdata_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            base_q     <= base_d;
            wdata_q    <= wdata_d;
            wr_first_q <= wr_first_d;
            rdata_q    <= rdata_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        base_d     = base_q;
        wdata_d    = wdata_q;
        wr_first_d = 1'b0;
        rdata_d    = rdata_q;
        case (state_q)
            IDLE: begin
                if (save_req) begin
                    state_d = SAVE_RD;
                    idx_d   = 5'd1;
                    base_d  = base_addr & 32'hFFFF_FFFC;
                end else if (restore_req) begin
                    state_d = RST_RD;
                    idx_d   = 5'd1;
                    base_d  = base_addr & 32'hFFFF_FFFC;
                end
            end
            SAVE_RD: begin
                state_d    = SAVE_WR;
                wr_first_d = 1'b1;
            end
            SAVE_WR: begin
                wdata_d = wdata_cur;
                if (mem_ack) begin
                    if (last_idx) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 5'd1;
                        state_d = SAVE_RD;
                    end
                end
            end
            RST_RD: begin
                if (mem_ack) begin
                    rdata_d = mem_rdata;
                    state_d = RST_WR;
                end
            end
            RST_WR: begin
                if (last_idx) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 5'd1;
                    state_d = RST_RD;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the registered state so that reset clears
    // them immediately, without waiting for a clock edge.
    always_comb begin
        busy         = (state_q != IDLE);
        done         = (state_q == DONE);
        rf_read_reg  = 5'd0;
        rf_reg_write = 1'b0;
        rf_write_reg = 5'd0;
        rf_write_bus = 32'd0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = 32'd0;
        mem_wdata    = 32'd0;
        case (state_q)
            SAVE_RD: rf_read_reg = idx_q;
            SAVE_WR: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = req_addr;
                mem_wdata = wdata_cur;
            end
            RST_RD: begin
                mem_req  = 1'b1;
                mem_addr = req_addr;
            end
            RST_WR: begin
                rf_reg_write = 1'b1;
                rf_write_reg = idx_q;
                rf_write_bus = rdata_q;
            end
            default: ;
        endcase
    end

endmodule
